// File: rtl/weight_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_packer_if
// Description : 32-bit weight stream (valid/ready/last) into the weight packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_packer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/weight_packer.sv
`default_nettype none
// ============================================================================
// Module      : weight_packer
// Description : Packs 32-bit weight words into 5*MAC_NUM-bit BRAM lines.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_packer #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    weight_packer_if.slave                s_if,
    output logic [5*MAC_NUM-1:0]          bram_wr_data,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_wr_addr,
    output logic                          bram_wr_en,
    output logic                          load_done,
    output logic                          addr_overflow
);
    localparam int LINE_W = 5 * MAC_NUM;
    localparam int WPL    = (LINE_W + 31) / 32;
    localparam int IDX_W  = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [BRAM_ADDRESS_WIDTH-1:0]   r_addr;
    logic [LINE_W-1:0]               r_buf;
    logic                            r_last;
    logic                            r_s_ready;
    logic                            r_wr_en;
    logic                            r_done;
    logic                            r_ovf;
    logic [LINE_W-1:0]               w_buf_next;
    logic                            w_hs;
    logic                            w_line_end;

    // Each slot takes s_data only when the index points at it; the top slot
    // may be narrower than 32 bits, so its excess input bits are dropped.
    for (genvar k = 0; k < WPL; k++) begin : g_slot
        localparam int LO = 32 * k;
        localparam int HI = (32 * k + 31 < LINE_W) ? (32 * k + 31) : (LINE_W - 1);
        assign w_buf_next[HI:LO] = (r_idx == IDX_W'(k)) ? s_if.s_data[HI-LO:0]
                                                        : r_buf[HI:LO];
    end

    assign w_hs       = s_if.s_valid && r_s_ready;
    assign w_line_end = (r_idx == IDX_W'(WPL - 1)) || s_if.s_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_addr    <= '0;
            r_buf     <= '0;
            r_last    <= 1'b0;
            r_s_ready <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state   <= S_FILL;
                        r_idx     <= '0;
                        r_addr    <= '0;
                        r_buf     <= '0;
                        r_last    <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_s_ready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_buf <= w_buf_next;
                        r_idx <= r_idx + 1'b1;
                        if (w_line_end) begin
                            r_state   <= S_WRITE;
                            r_s_ready <= 1'b0;
                            r_wr_en   <= 1'b1;
                            r_last    <= s_if.s_last;
                        end
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_addr  <= r_addr + 1'b1;
                    r_idx   <= '0;
                    r_buf   <= '0;
                    if (&r_addr) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_FILL;
                        r_s_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_if.s_ready  = r_s_ready;
    assign bram_wr_data  = r_buf;
    assign bram_wr_addr  = r_addr;
    assign bram_wr_en    = r_wr_en;
    assign load_done     = r_done;
    assign addr_overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_weight_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_packer
// Description : Directed self-checking bench for weight_packer (MAC_NUM=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_packer;
    localparam int MAC = 32;
    localparam int AW  = 2;
    localparam int LW  = 5 * MAC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [LW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          load_done;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [LW-1:0] q_data[$];
    logic [AW-1:0] q_addr[$];
    int            q_cyc[$];
    logic          q_ovf[$];
    int            done_cyc = 0;
    int            n_done = 0;
    int            ready_bad = 0;

    always #5 clk = ~clk;

    weight_packer_if u_if ();

    weight_packer #(
        .MAC_NUM            (MAC),
        .BRAM_ADDRESS_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .s_if          (u_if.slave),
        .bram_wr_data  (wr_data),
        .bram_wr_addr  (wr_addr),
        .bram_wr_en    (wr_en),
        .load_done     (load_done),
        .addr_overflow (ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / done logger, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            q_data.push_back(wr_data);
            q_addr.push_back(wr_addr);
            q_cyc.push_back(cyc);
            q_ovf.push_back(ovf);
        end
        if (load_done) begin
            done_cyc = cyc;
            n_done++;
        end
        if ((wr_en || load_done) && u_if.s_ready) ready_bad++;
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_data.delete();
        q_addr.delete();
        q_cyc.delete();
        q_ovf.delete();
        n_done    = 0;
        done_cyc  = 0;
        ready_bad = 0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        u_if.s_data  = d;
        u_if.s_valid = 1'b1;
        u_if.s_last  = l;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = u_if.s_ready;
            @(posedge clk); #1;
            n++;
        end
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
        chk("accept", LW'(acc), LW'(1));
    endtask

    task automatic gap(input int n);
        u_if.s_valid = 1'b0;
        u_if.s_data  = $urandom;
        u_if.s_last  = 1'($urandom);
        repeat (n) begin
            @(posedge clk); #1;
        end
        u_if.s_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!load_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", LW'(load_done), LW'(1));
        @(posedge clk); #1;
    endtask

    logic [LW-1:0] exp_line;

    initial begin
        u_if.s_data  = '0;
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", LW'(u_if.s_ready), '0);
        chk("rst_wr_en", LW'(wr_en), '0);
        chk("rst_done",  LW'(load_done), '0);
        chk("rst_ovf",   LW'(ovf), '0);
        chk("rst_addr",  LW'(wr_addr), '0);
        chk("rst_data",  wr_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two full lines, back-to-back
        clear_log();
        pulse_start();
        chk("fill_ready", LW'(u_if.s_ready), LW'(1));
        for (int i = 1; i <= 10; i++) send(32'(i), i == 10);
        wait_done();
        chk("b2b_nstrobe", LW'(q_data.size()), LW'(2));
        chk("b2b_addr0", LW'(q_addr[0]), LW'(0));
        chk("b2b_data0", q_data[0], {32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
        chk("b2b_addr1", LW'(q_addr[1]), LW'(1));
        chk("b2b_data1", q_data[1], {32'hA, 32'h9, 32'h8, 32'h7, 32'h6});
        chk("b2b_done_lat", LW'(done_cyc), LW'(q_cyc[1] + 1));
        chk("b2b_ndone", LW'(n_done), LW'(1));
        chk("idle_ready", LW'(u_if.s_ready), '0);

        // Short line: s_last on the third word
        clear_log();
        pulse_start();
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b1);
        wait_done();
        chk("short_nstrobe", LW'(q_data.size()), LW'(1));
        chk("short_addr", LW'(q_addr[0]), LW'(0));
        chk("short_data", q_data[0], {32'h0, 32'h0, 32'h3, 32'h2, 32'h1});
        chk("short_ready_low", LW'(ready_bad), '0);

        // Two lines with random s_valid gaps and junk data while idle
        clear_log();
        pulse_start();
        for (int i = 1; i <= 10; i++) begin
            gap($urandom_range(0, 3));
            send(32'(i), i == 10);
        end
        wait_done();
        chk("gap_nstrobe", LW'(q_data.size()), LW'(2));
        chk("gap_addr0", LW'(q_addr[0]), LW'(0));
        chk("gap_data0", q_data[0], {32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
        chk("gap_addr1", LW'(q_addr[1]), LW'(1));
        chk("gap_data1", q_data[1], {32'hA, 32'h9, 32'h8, 32'h7, 32'h6});
        chk("gap_ready_low", LW'(ready_bad), '0);

        // Five lines: address wraps 3 -> 0 and overflow becomes sticky
        clear_log();
        pulse_start();
        for (int i = 0; i < 25; i++) send(32'h100 + 32'(i), i == 24);
        wait_done();
        chk("wrap_nstrobe", LW'(q_data.size()), LW'(5));
        for (int j = 0; j < 5; j++) begin
            exp_line = '0;
            for (int k = 0; k < 5; k++) exp_line[32*k +: 32] = 32'h100 + 32'(5 * j + k);
            chk($sformatf("wrap_addr%0d", j), LW'(q_addr[j]), LW'(j % 4));
            chk($sformatf("wrap_data%0d", j), q_data[j], exp_line);
        end
        chk("wrap_ovf_at4", LW'(q_ovf[3]), '0);
        chk("wrap_ovf_at5", LW'(q_ovf[4]), LW'(1));
        chk("wrap_ovf_sticky", LW'(ovf), LW'(1));
        pulse_start();
        chk("wrap_ovf_clear", LW'(ovf), '0);

        // Abort by reset after three words, then a fresh load
        clear_log();
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", LW'(u_if.s_ready), '0);
        chk("abort_data", wr_data, '0);
        @(posedge clk); #1;
        pulse_start();
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        load_start = 1'b1;
        send(32'hB3, 1'b0);
        load_start = 1'b0;
        send(32'hB4, 1'b0);
        send(32'hB5, 1'b1);
        wait_done();
        chk("abort_nstrobe", LW'(q_data.size()), LW'(1));
        chk("abort_addr", LW'(q_addr[0]), LW'(0));
        chk("abort_new_data", q_data[0], {32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
